wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and queued load results onto one register-file write port,
// and tracks outstanding loads in a scoreboard for decode hazard detection.
module wb_arbiter #(
   parameter int LDQ_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        ld_valid,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_data,
   output logic        ld_ready,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic        hazard1,
   output logic        hazard2,
   output logic        reg_wr_en,
   output logic [4:0]  reg_wr_rd,
   output logic [31:0] reg_wr_dat
);

   localparam int PTR_W = $clog2(LDQ_DEPTH);
   localparam int CNT_W = $clog2(LDQ_DEPTH + 1);

   logic [4:0]       q_rd   [LDQ_DEPTH];
   logic [31:0]      q_data [LDQ_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [31:0]      pending;
   logic [31:0]      pending_nxt;

   logic        full;
   logic        drain;
   logic        enq;
   logic        sel_valid;
   logic [4:0]  sel_rd;
   logic [31:0] sel_data;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(LDQ_DEPTH - 1))
         return '0;
      else
         return p + PTR_W'(1);
   endfunction

   // A full queue takes priority over the ALU so loads can never be starved.
   assign full      = (count == CNT_W'(LDQ_DEPTH));
   assign ld_ready  = !full;
   assign drain     = (count != '0) && (!alu_valid || full);
   assign alu_ready = !drain;
   assign enq       = ld_valid && ld_ready;

   assign hazard1 = pending[rs1] && (rs1 != 5'd0);
   assign hazard2 = pending[rs2] && (rs2 != 5'd0);

   always_comb begin
      sel_valid = 1'b0;
      sel_rd    = '0;
      sel_data  = '0;
      if (drain) begin
         sel_valid = 1'b1;
         sel_rd    = q_rd[rd_ptr];
         sel_data  = q_data[rd_ptr];
      end else if (alu_valid) begin
         sel_valid = 1'b1;
         sel_rd    = alu_rd;
         sel_data  = alu_data;
      end
   end

   // Clear first, then set, so a same-cycle reissue of the register stays pending.
   always_comb begin
      pending_nxt = pending;
      if (drain && (q_rd[rd_ptr] != 5'd0))
         pending_nxt[q_rd[rd_ptr]] = 1'b0;
      if (issue_valid && (issue_rd != 5'd0))
         pending_nxt[issue_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (enq && !reset) begin
         q_rd[wr_ptr]   <= ld_rd;
         q_data[wr_ptr] <= ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         pending    <= '0;
         reg_wr_en  <= 1'b0;
         reg_wr_rd  <= '0;
         reg_wr_dat <= '0;
      end else begin
         if (enq)
            wr_ptr <= ptr_inc(wr_ptr);
         if (drain)
            rd_ptr <= ptr_inc(rd_ptr);
         case ({enq, drain})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         pending   <= pending_nxt;
         reg_wr_en <= sel_valid && (sel_rd != 5'd0);
         if (sel_valid && (sel_rd != 5'd0)) begin
            reg_wr_rd  <= sel_rd;
            reg_wr_dat <= sel_data;
         end
      end
   end

endmodule
